// File: rtl/conv_pkg.sv
// Shared conv kernel types: result word, column index and OFM drain defaults.
package conv_pkg;
  localparam int CONV_COL       = 8;
  localparam int CONV_OFM_WIDTH = 32;
  localparam int OFM_FIFO_DEPTH = 4;

  typedef logic signed [CONV_OFM_WIDTH-1:0] sum_t;
  typedef logic [$clog2(CONV_COL)-1:0]      col_idx_t;
endpackage

// File: rtl/ofm_col_fifo.sv
// Single-column first-word-fall-through FIFO; flush empties it in one cycle.
module ofm_col_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // a pop in the same cycle frees the slot, so a push onto a full FIFO still lands
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end
endmodule

// File: rtl/conv_ofm_drain.sv
// Per-column result capture and strict column-order re-serialization to the OFM stream.
// Define OFM_RELU_EN to clamp negative results to zero at the output mux.
module conv_ofm_drain
  import conv_pkg::*;
#(
  parameter int COL        = CONV_COL,
  parameter int OFM_WIDTH  = CONV_OFM_WIDTH,
  parameter int FIFO_DEPTH = OFM_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start_conv,
  input  logic [COL-1:0]                cfg_col_en,
  input  logic                          conv_done,
  input  logic [COL-1:0]                sum_valid,
  input  logic [COL-1:0][OFM_WIDTH-1:0] sum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OFM_WIDTH-1:0]          out_data,
  output logic [$clog2(COL)-1:0]        out_col,
  output logic                          drain_done,
  output logic                          ovf_err
);
  localparam int CIW = $clog2(COL);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [COL-1:0]                col_en, push, pop, full, empty, drop, will_empty;
  logic [COL-1:0][OFM_WIDTH-1:0] head;
  logic [COL-1:0][CW-1:0]        cnt;
  logic [CIW-1:0]                col_ptr, ptr_next, ptr_first;
  logic                          done_seen, xfer, fire;

  assign push      = sum_valid & col_en & {COL{~start_conv}};
  assign out_valid = ~empty[col_ptr];
  assign out_col   = col_ptr;
  assign xfer      = out_valid & out_ready;

  for (genvar g = 0; g < COL; g++) begin : g_col
    assign pop[g]        = xfer && (col_ptr == CIW'(g));
    assign drop[g]       = push[g] & full[g] & ~pop[g];
    // empty after this edge, so drain_done lands the cycle after the last pop
    assign will_empty[g] = empty[g] | (pop[g] & (cnt[g] == CW'(1)));

    ofm_col_fifo #(.W(OFM_WIDTH), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .flush (start_conv),
      .push  (push[g]),
      .data  (sum[g]),
      .pop   (pop[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .count (cnt[g]),
      .head  (head[g])
    );
  end

  always_comb begin
    int idx;
    idx       = 0;
    ptr_next  = col_ptr;
    ptr_first = '0;
    // descending scan: last hit is the nearest enabled column after col_ptr
    for (int k = COL - 1; k >= 1; k--) begin
      idx = (int'(col_ptr) + k) % COL;
      if (col_en[idx]) ptr_next = CIW'(idx);
    end
    for (int k = COL - 1; k >= 0; k--) begin
      if (cfg_col_en[k]) ptr_first = CIW'(k);
    end
  end

  assign fire = (done_seen | conv_done) & (&will_empty) & ~(|push) & ~start_conv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_en     <= '1;
      col_ptr    <= '0;
      done_seen  <= 1'b0;
      drain_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else if (start_conv) begin
      col_en     <= cfg_col_en;
      col_ptr    <= ptr_first;
      done_seen  <= 1'b0;
      drain_done <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      drain_done <= fire;
      done_seen  <= (done_seen | conv_done) & ~fire;
      ovf_err    <= ovf_err | (|drop);
      if (xfer) col_ptr <= ptr_next;
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
`ifdef OFM_RELU_EN
      out_data = head[col_ptr][OFM_WIDTH-1] ? '0 : head[col_ptr];
`else
      out_data = head[col_ptr];
`endif
    end
  end
endmodule

// File: tb/tb_conv_ofm_drain.sv
// Randomized bench for conv_ofm_drain against a queue-based reference model.
module tb_conv_ofm_drain;
  localparam int COL = 8;
  localparam int W   = 32;
  localparam int D   = 4;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  start_conv;
  logic [COL-1:0]        cfg_col_en;
  logic                  conv_done;
  logic [COL-1:0]        sum_valid;
  logic [COL-1:0][W-1:0] sum;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data;
  logic [2:0]            out_col;
  logic                  drain_done;
  logic                  ovf_err;

  conv_ofm_drain #(.COL(COL), .OFM_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .start_conv(start_conv), .cfg_col_en(cfg_col_en),
    .conv_done(conv_done), .sum_valid(sum_valid), .sum(sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .drain_done(drain_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int drain_pulses = 0;

  // reference state: one queue per column plus the layer bookkeeping
  logic [W-1:0]   mq[COL][$];
  logic [COL-1:0] m_en;
  int             m_ptr;
  bit             m_ovf, m_done, m_drain;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] relu(logic [W-1:0] v);
`ifdef OFM_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_step();
    bit xfer, anyp, allmt;
    int p;
    if (start_conv) begin
      for (int i = 0; i < COL; i++) mq[i].delete();
      m_en  = cfg_col_en;
      m_ptr = 0;
      for (int i = COL - 1; i >= 0; i--) if (cfg_col_en[i]) m_ptr = i;
      m_ovf = 0; m_done = 0; m_drain = 0;
      return;
    end
    p    = m_ptr;
    xfer = out_ready && (mq[p].size() > 0);
    if (xfer) void'(mq[p].pop_front());
    anyp = 0;
    for (int i = 0; i < COL; i++) begin
      if (sum_valid[i] && m_en[i]) begin
        anyp = 1;
        if (mq[i].size() < D) mq[i].push_back(sum[i]);
        else m_ovf = 1;
      end
    end
    allmt = 1;
    for (int i = 0; i < COL; i++) if (mq[i].size() != 0) allmt = 0;
    m_drain = (m_done || conv_done) && allmt && !anyp;
    m_done  = (m_done || conv_done) && !m_drain;
    if (xfer) begin
      for (int k = 1; k <= COL; k++) begin
        if (m_en[(p + k) % COL]) begin
          m_ptr = (p + k) % COL;
          break;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(mq[m_ptr].size() > 0));
    chk("out_col", 32'(out_col), 32'(m_ptr));
    if (mq[m_ptr].size() > 0) chk("out_data", out_data, relu(mq[m_ptr][0]));
    chk("drain_done", 32'(drain_done), 32'(m_drain));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (drain_done) drain_pulses++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [COL-1:0] sv, bit rdy);
    sum_valid = sv;
    out_ready = rdy;
    cycle();
    sum_valid = '0;
  endtask

  task automatic start(logic [COL-1:0] mask);
    cfg_col_en = mask;
    start_conv = 1'b1;
    cycle();
    start_conv = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start_conv = 0; cfg_col_en = '0; conv_done = 0;
    sum_valid = '0; sum = '0; out_ready = 0;
    m_en = '1; m_ptr = 0; m_ovf = 0; m_done = 0; m_drain = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_col", 32'(out_col), 32'd0);
    chk("rst_drain", 32'(drain_done), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // all columns strobe at once, drain in column order
    for (int i = 0; i < COL; i++) sum[i] = 100 + i;
    drv('1, 1);
    repeat (10) drv('0, 1);

    // strict order: column 3 waits behind an empty column 2
    start(8'b1111_1100);
    sum[3] = 33;
    drv(8'h08, 1);
    repeat (3) drv('0, 1);
    sum[2] = 22;
    drv(8'h04, 1);
    repeat (4) drv('0, 1);

    // overflow on column 0, sticky until next start
    start('1);
    for (int k = 0; k < 5; k++) begin
      sum[0] = 32'(k + 1);
      drv(8'h01, 0);
    end
    repeat (2) drv('0, 0);
    repeat (8) drv('0, 1);

    // sparse column mask
    start(8'b0010_0100);
    repeat (30) begin
      for (int i = 0; i < COL; i++) sum[i] = $urandom;
      drv(COL'($urandom), ($urandom % 4) != 0);
    end
    repeat (8) drv('0, 1);

    // completion with 3 words buffered and toggling ready
    start('1);
    for (int i = 0; i < COL; i++) sum[i] = 200 + i;
    drv(8'h07, 0);
    conv_done = 1;
    drv('0, 0);
    conv_done = 0;
    drain_pulses = 0;
    for (int k = 0; k < 12; k++) drv('0, k % 2 == 0);
    chk("drain_once", 32'(drain_pulses), 32'd1);

    // signed values through the output mux
    start('1);
    sum[0] = -32'sd7;
    sum[1] = 32'sd9;
    drv(8'h03, 1);
    repeat (3) drv('0, 1);

    // empty mask: nothing emitted, drain_done the cycle after conv_done
    start('0);
    conv_done = 1;
    drv(COL'($urandom), 1);
    conv_done = 0;
    repeat (3) drv(COL'($urandom), 1);

    // random soak
    start('1);
    repeat (400) begin
      for (int i = 0; i < COL; i++) sum[i] = $urandom;
      conv_done = ($urandom % 20) == 0;
      if (($urandom % 60) == 0) begin
        cfg_col_en = ($urandom % 8 == 0) ? '0 : COL'($urandom);
        start_conv = 1'b1;
      end
      drv(COL'($urandom & $urandom), ($urandom % 3) != 0);
      start_conv = 1'b0;
      conv_done  = 1'b0;
    end
    repeat (40) drv('0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
